pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the instruction decoder.
- Holds the PC and requests instruction words from instruction memory over a valid handshake.
- Presents one held instruction at a time to decode/execute.
- On an advance pulse, computes the next PC from the decoder's 2-bit muxPC select, the jump/branch fields of the held instruction and the jr register value.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the requested word; equals pc.
- imem_valid  input  1  memory response valid; one pulse per request.
- imem_rdata  input  32  instruction word; sampled when imem_valid=1.
- instr  output  32  held instruction feeding the decoder (opcode=[31:26], functcode=[5:0]).
- instr_valid  output  1  instr is held and ready for execution.
- pc  output  32  address of the held/in-flight instruction.
- pc_plus4  output  32  pc+4; used as the JAL link value.
- advance  input  1  execute stage retires the held instruction this cycle.
- muxPC  input  2  next-PC select from the decoder (codes below).
- jr_target  input  32  register-file rs value for JR.
- misalign_err  output  1  sticky flag: a misaligned JR target was seen.
- retired_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign_err=0, retired_cnt=0.
  - FSM enters BOOT.
- FSM states:
  - BOOT: imem_req=0 for exactly one cycle, then go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid: instr<=imem_rdata, go to HOLD. Zero-wait response (imem_valid in the first FETCH cycle) is legal.
  - HOLD: imem_req=0, instr_valid=1. On advance: pc<=next_pc, retired_cnt++, go to FETCH. Without advance, stay in HOLD with instr stable.
- Latency:
  - instr_valid rises the cycle after the imem_valid sample.
  - The new pc is visible the cycle after advance, and imem_req rises the same cycle.
- Next-PC select (p4 = pc+4, modulo 2^32):
  - 0 SEQ: p4.
  - 1 JUMP: {p4[31:28], instr[25:0], 2'b00}.
  - 2 JR: {jr_target[31:2], 2'b00}. If jr_target[1:0]!=0, set misalign_err (cleared only by reset).
  - 3 BRANCH: p4 + (sign-extended instr[15:0] << 2).
- Arithmetic: 32-bit, wrap-around with no overflow detection; e.g. SEQ from 32'hFFFF_FFFC gives 0.
- Ignored inputs:
  - advance outside HOLD: no effect on pc or retired_cnt.
  - imem_valid outside FETCH.
  - muxPC and jr_target when advance=0.
- Reset priority: reset wins over every simultaneous event, including mid-FETCH or an imem_valid in the same cycle. The in-flight response is discarded and the memory aborts on the same reset.
- retired_cnt wraps to 0 at 2^CNT_W.
- No outputs are X after the first reset edge.

Decomposition:
- Shared package `pc_defs`:
  - muxPC codes PC_SEQ=2'd0, PC_JUMP=2'd1, PC_JR=2'd2, PC_BRANCH=2'd3. These are the same encoding the instruction decoder drives.
  - FSM state encodings BOOT/FETCH/HOLD.
- One combinational sub-module, `next_pc_calc`:
  - Inputs: pc, instr, jr_target, muxPC.
  - Outputs: next_pc, misaligned.
  - Unit-testable standalone.
- The sequential FSM, pc register, instruction register and counter stay in pc_fetch_unit.

Test Plan:
1. Reset: hold reset 2 cycles, release -> one cycle imem_req=0, then imem_req=1, imem_addr=0, instr_valid=0, retired_cnt=0.
2. Sequential fetch:
   - Stimulus: respond 2 cycles after the request with imem_rdata=32'h2009_0005; one cycle later pulse advance with muxPC=0.
   - Response: instr_valid=1 and instr=32'h2009_0005 the cycle after imem_valid; after advance, pc=4, imem_addr=4, retired_cnt=1.
3. Jump: pc=32'h0040_0010, instr=32'h0810_0008, advance with muxPC=1 -> pc=32'h0040_0020.
4. Backward branch: pc=32'h20, instr[15:0]=16'hFFFE, advance with muxPC=3 -> pc=32'h1C. Then with muxPC=0 from pc=32'hFFFF_FFFC -> pc=0.
5. JR misaligned: jr_target=32'h103, muxPC=2, advance -> pc=32'h100, misalign_err=1. It stays 1 through later advances until reset.
6. Reset mid-operation:
   - Stimulus: assert reset in FETCH in the same cycle as imem_valid=1 (rdata=32'hDEAD_BEEF).
   - Response: instr_valid=0, instr=0, pc=RESET_PC. A stray advance in the following BOOT/FETCH cycles leaves pc and retired_cnt unchanged.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared next-PC select codes and fetch FSM encodings
package pc_defs;

  // Next-PC select, same encoding the instruction decoder drives
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_JUMP   = 2'd1,
    PC_JR     = 2'd2,
    PC_BRANCH = 2'd3
  } mux_pc_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory and decode/execute signal bundle
interface pc_fetch_unit_if #(
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_valid;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             advance;
  logic [1:0]       muxPC;
  logic [31:0]      jr_target;
  logic             misalign_err;
  logic [CNT_W-1:0] retired_cnt;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           misalign_err, retired_cnt,
    input  imem_valid, imem_rdata, advance, muxPC, jr_target
  );

  // Memory / decoder / execute side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
           misalign_err, retired_cnt,
    output imem_valid, imem_rdata, advance, muxPC, jr_target
  );
endinterface

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// rtl/pc_fetch_unit_next_pc_calc.sv - combinational next-PC selection
module next_pc_calc
  import pc_defs::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_jr_target,
  input  logic [1:0]  i_muxPC,
  output logic [31:0] o_next_pc,
  output logic        o_misaligned
);
  logic [31:0] w_p4;
  logic [31:0] w_br_off;

  assign w_p4     = i_pc + PC_STEP;
  assign w_br_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

  // Select the next PC; JR drops the low bits and reports them instead
  always_comb begin
    o_next_pc    = w_p4;
    o_misaligned = 1'b0;
    case (i_muxPC)
      PC_SEQ:    o_next_pc = w_p4;
      PC_JUMP:   o_next_pc = {w_p4[31:28], i_instr[25:0], 2'b00};
      PC_JR: begin
        o_next_pc    = {i_jr_target[31:2], 2'b00};
        o_misaligned = (i_jr_target[1:0] != 2'b00);
      end
      PC_BRANCH: o_next_pc = w_p4 + w_br_off;
      default:   o_next_pc = w_p4;
    endcase
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, fetch handshake FSM and retired counter
module pc_fetch_unit
  import pc_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic              clk,
  input logic              reset,
  pc_fetch_unit_if.master  bus
);
  fetch_state_t     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_valid;
  logic             r_req;
  logic             r_mis;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      w_next_pc;
  logic             w_misaligned;

  next_pc_calc u_next_pc (
    .i_pc        (r_pc),
    .i_instr     (r_instr),
    .i_jr_target (bus.jr_target),
    .i_muxPC     (bus.muxPC),
    .o_next_pc   (w_next_pc),
    .o_misaligned(w_misaligned)
  );

  assign bus.imem_req     = r_req;
  assign bus.imem_addr    = r_pc;
  assign bus.instr        = r_instr;
  assign bus.instr_valid  = r_valid;
  assign bus.pc           = r_pc;
  assign bus.pc_plus4     = r_pc + PC_STEP;
  assign bus.misalign_err = r_mis;
  assign bus.retired_cnt  = r_cnt;

  // Fetch FSM; reset overrides any response or advance in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= 32'd0;
      r_valid <= 1'b0;
      r_req   <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_req   <= 1'b1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.imem_valid) begin
            r_instr <= bus.imem_rdata;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.advance) begin
            r_pc    <= w_next_pc;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            if (w_misaligned) r_mis <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_BOOT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.CNT_W(32)) bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] q_instr[$];
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_mis = 1'b0;
  logic [31:0] cur_instr = 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [31:0] jr, input logic [1:0] sel);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    case (sel)
      2'd0:    return p4;
      2'd1:    return {p4[31:28], ins[25:0], 2'b00};
      2'd2:    return {jr[31:2], 2'b00};
      default: return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    endcase
  endfunction

  task automatic do_fetch(input logic [31:0] word, input int lat);
    int n;
    logic [31:0] e;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
    chk("imem_addr", bus.imem_addr, exp_pc);
    repeat (lat) step();
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    q_instr.push_back(word);
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    chk("instr_valid", 32'(bus.instr_valid), 32'd1);
    if (q_instr.size() != 0) begin
      e = q_instr.pop_front();
      chk("instr", bus.instr, e);
      cur_instr = e;
    end
  endtask

  task automatic do_adv(input logic [1:0] sel, input logic [31:0] jr);
    bus.advance   = 1'b1;
    bus.muxPC     = sel;
    bus.jr_target = jr;
    exp_pc  = model_next(exp_pc, cur_instr, jr, sel);
    exp_cnt = exp_cnt + 32'd1;
    if (sel == 2'd2 && jr[1:0] != 2'b00) exp_mis = 1'b1;
    step();
    bus.advance   = 1'b0;
    bus.muxPC     = 2'd0;
    bus.jr_target = 32'd0;
    chk("adv_pc", bus.pc, exp_pc);
    chk("adv_req", 32'(bus.imem_req), 32'd1);
    chk("adv_valid", 32'(bus.instr_valid), 32'd0);
    chk("adv_cnt", bus.retired_cnt, exp_cnt);
    chk("adv_mis", 32'(bus.misalign_err), 32'(exp_mis));
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.advance    = 1'b0;
    bus.muxPC      = 2'd0;
    bus.jr_target  = 32'd0;

    // Reset for two cycles, then one BOOT cycle without request
    step();
    step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_cnt", bus.retired_cnt, 32'd0);
    chk("rst_mis", 32'(bus.misalign_err), 32'd0);
    reset = 1'b0;
    chk("boot_req", 32'(bus.imem_req), 32'd0);
    step();
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, 32'd0);
    chk("fetch_valid", 32'(bus.instr_valid), 32'd0);

    // Stray advance while fetching must be ignored
    bus.advance = 1'b1;
    step();
    bus.advance = 1'b0;
    chk("stray_adv_pc", bus.pc, 32'd0);
    chk("stray_adv_cnt", bus.retired_cnt, 32'd0);

    // Sequential fetch, response two cycles after request
    do_fetch(32'h2009_0005, 2);
    chk("pc_plus4", bus.pc_plus4, 32'd4);
    // Held instruction stays stable; imem_valid in HOLD is ignored
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    step();
    bus.imem_valid = 1'b0;
    step();
    chk("hold_instr", bus.instr, 32'h2009_0005);
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
    do_adv(2'd0, 32'd0);
    chk("seq_pc", bus.pc, 32'd4);
    chk("seq_addr", bus.imem_addr, 32'd4);
    chk("seq_cnt", bus.retired_cnt, 32'd1);

    // Jump from 0x0040_0010
    do_fetch(32'h0000_0008, 0);
    do_adv(2'd2, 32'h0040_0010);
    do_fetch(32'h0810_0008, 1);
    do_adv(2'd1, 32'd0);
    chk("jump_pc", bus.pc, 32'h0040_0020);

    // Backward branch from 0x20
    do_fetch(32'h0000_0008, 0);
    do_adv(2'd2, 32'h0000_0020);
    do_fetch(32'h1000_FFFE, 0);
    do_adv(2'd3, 32'd0);
    chk("branch_pc", bus.pc, 32'h0000_001C);

    // Sequential wrap from the top of the address space
    do_fetch(32'h0000_0008, 0);
    do_adv(2'd2, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0000, 0);
    do_adv(2'd0, 32'd0);
    chk("wrap_pc", bus.pc, 32'd0);

    // Misaligned JR target is truncated and flagged stickily
    do_fetch(32'h0000_0008, 0);
    do_adv(2'd2, 32'h0000_0103);
    chk("jr_pc", bus.pc, 32'h0000_0100);
    chk("jr_mis", 32'(bus.misalign_err), 32'd1);
    do_fetch(32'h0000_0000, 0);
    do_adv(2'd0, 32'd0);
    chk("mis_sticky", 32'(bus.misalign_err), 32'd1);
    chk("sticky_pc", bus.pc, 32'h0000_0104);

    // Reset in FETCH coinciding with a memory response
    step();
    reset          = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    reset          = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("mid_rst_instr", bus.instr, 32'd0);
    chk("mid_rst_pc", bus.pc, 32'd0);
    chk("mid_rst_mis", 32'(bus.misalign_err), 32'd0);
    chk("mid_rst_cnt", bus.retired_cnt, 32'd0);
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    bus.advance = 1'b1;
    bus.muxPC   = 2'd2;
    bus.jr_target = 32'h0000_0800;
    step();
    chk("boot_adv_pc", bus.pc, 32'd0);
    chk("boot_adv_cnt", bus.retired_cnt, 32'd0);
    chk("boot_adv_req", 32'(bus.imem_req), 32'd1);
    step();
    bus.advance = 1'b0;
    bus.muxPC   = 2'd0;
    bus.jr_target = 32'd0;
    chk("fetch_adv_pc", bus.pc, 32'd0);
    chk("fetch_adv_cnt", bus.retired_cnt, 32'd0);
    chk("sb_empty", 32'(q_instr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
